// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor: supervisor states and
// the width helper used to size the shared cycle counter.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } pll_state_e;

  // One counter serves every timed state, so it must hold the largest terminal count.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; output resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Capture stage followed by the settling stage
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, waits for a stable lock, then releases the core reset;
// retries a bounded number of times before latching a fault.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       retry_req,
  output logic       pll_rst,
  output logic       core_reset,
  output logic       ready,
  output logic       fault,
  output logic [7:0] lol_count
);

  localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRIES);

  logic          locked_s;
  pll_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retries_q, retries_d;
  logic [7:0]    lol_q, lol_d;
  logic          pll_rst_q, pll_rst_d;
  logic          core_reset_q, core_reset_d;
  logic          ready_q, ready_d;
  logic          fault_q, fault_d;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  // Next-state, counter and output decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retries_d = retries_q;
    lol_d     = lol_q;
    case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAIT_LOCK: begin
        // Lock takes priority over a timeout landing on the same cycle
        if (locked_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_LAST) begin
          cnt_d = '0;
          if (retries_q < RETRY_MAX) begin
            state_d   = ST_PLL_RST;
            retries_d = retries_q + 4'd1;
          end else begin
            state_d = ST_FAULT;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_STABLE: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d   = ST_PLL_RST;
          cnt_d     = '0;
          retries_d = 4'd0;
          lol_d     = (lol_q == 8'hFF) ? lol_q : lol_q + 8'd1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FAULT: begin
        if (retry_req) begin
          state_d   = ST_PLL_RST;
          cnt_d     = '0;
          retries_d = 4'd0;
        end else begin
          state_d = ST_FAULT;
        end
      end
      default: begin
        state_d = ST_PLL_RST;
        cnt_d   = '0;
      end
    endcase
    pll_rst_d    = (state_d == ST_PLL_RST) || (state_d == ST_FAULT);
    core_reset_d = (state_d != ST_RUN);
    ready_d      = (state_d == ST_RUN);
    fault_d      = (state_d == ST_FAULT);
  end

  // State, counters and registered outputs
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q      <= ST_PLL_RST;
      cnt_q        <= '0;
      retries_q    <= 4'd0;
      lol_q        <= 8'd0;
      pll_rst_q    <= 1'b1;
      core_reset_q <= 1'b1;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retries_q    <= retries_d;
      lol_q        <= lol_d;
      pll_rst_q    <= pll_rst_d;
      core_reset_q <= core_reset_d;
      ready_q      <= ready_d;
      fault_q      <= fault_d;
    end
  end

  assign pll_rst    = pll_rst_q;
  assign core_reset = core_reset_q;
  assign ready      = ready_q;
  assign fault      = fault_q;
  assign lol_count  = lol_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench: expected output vectors are queued per refclk edge as each
// stimulus phase is set up, and compared on the following falling edge.
module tb_pll_lock_supervisor;

  localparam logic [3:0] PR = 4'b1100;  // {pll_rst, core_reset, ready, fault}
  localparam logic [3:0] WT = 4'b0100;
  localparam logic [3:0] RN = 4'b0010;
  localparam logic [3:0] FT = 4'b1101;

  logic       refclk     = 1'b0;
  logic       rst        = 1'b1;
  logic       pll_locked = 1'b0;
  logic       retry_req  = 1'b0;
  logic       pll_rst, core_reset, ready, fault;
  logic [7:0] lol_count;

  int cyc      = 0;
  int e0       = 3;
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          at;
    string       tag;
    logic [11:0] exp;
  } exp_t;
  exp_t sb[$];

  pll_lock_supervisor #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .retry_req  (retry_req),
    .pll_rst    (pll_rst),
    .core_reset (core_reset),
    .ready      (ready),
    .fault      (fault),
    .lol_count  (lol_count)
  );

  always #10 refclk = ~refclk;

  always @(posedge refclk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got pll_rst,core_reset,ready,fault=%b lol=%0d, required %b lol=%0d",
               tag, cyc, got[11:8], got[7:0], exp[11:8], exp[7:0]);
    end
  endtask

  task automatic expect_span(input string tag, input int from, input int to,
                             input logic [3:0] st, input logic [7:0] lol);
    for (int c = from; c <= to; c++) sb.push_back('{e0 + c, tag, {st, lol}});
  endtask

  task automatic at(input int off);
    while (cyc < e0 + off) begin
      @(posedge refclk);
      #1;
    end
  endtask

  always @(negedge refclk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      check_eq(e.tag, {pll_rst, core_reset, ready, fault, lol_count}, e.exp);
    end
  end

  initial begin
    // Power-on reset, first timeout, then lock arriving exactly on the timeout edge
    expect_span("reset",            -2,   3, PR, 8'd0);
    expect_span("wait_timeout1",     4,  23, WT, 8'd0);
    expect_span("retry1_pulse",     24,  27, PR, 8'd0);
    expect_span("wait_lock_at_to",  28,  47, WT, 8'd0);
    expect_span("stable",           48,  55, WT, 8'd0);
    expect_span("run",              56,  62, RN, 8'd0);
    // Loss of lock in RUN, then three pulses and a fault
    expect_span("lol_pulse",        63,  66, PR, 8'd1);
    expect_span("lol_wait",         67,  86, WT, 8'd1);
    expect_span("retry_a_pulse",    87,  90, PR, 8'd1);
    expect_span("retry_a_wait",     91, 110, WT, 8'd1);
    expect_span("retry_b_pulse",   111, 114, PR, 8'd1);
    expect_span("retry_b_wait",    115, 134, WT, 8'd1);
    expect_span("fault",           135, 140, FT, 8'd1);
    expect_span("fault_retry",     141, 144, PR, 8'd1);
    // Glitch during STABLE restarts the stable count without a PLL reset
    expect_span("glitch_wait",     145, 166, WT, 8'd1);
    expect_span("glitch_run",      167, 172, RN, 8'd1);
    expect_span("lol2_pulse",      173, 176, PR, 8'd2);
    expect_span("lol2_stable",     177, 186, WT, 8'd2);

    at(0);   rst = 1'b0;
    at(45);  pll_locked = 1'b1;
    at(60);  pll_locked = 1'b0;
    at(70);  retry_req  = 1'b1;
    at(71);  retry_req  = 1'b0;
    at(140); retry_req  = 1'b1;
    at(141); retry_req  = 1'b0;
    at(150); pll_locked = 1'b1;
    at(155); pll_locked = 1'b0;
    at(156); pll_locked = 1'b1;
    at(170); pll_locked = 1'b0;
    at(178); pll_locked = 1'b1;

    // Reset while STABLE count is 5; lock stays asserted through it
    expect_span("mid_reset_pulse", 187, 190, PR, 8'd0);
    expect_span("mid_reset_wait",  191, 199, WT, 8'd0);
    expect_span("mid_reset_run",   200, 205, RN, 8'd0);
    at(186); rst = 1'b1;
    at(187); rst = 1'b0;

    at(208);
    check_eq("scoreboard_drain", 12'(sb.size()), 12'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: bench did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: refclk cycles pll_rst is held per PLL reset pulse (min 1).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 50000: refclk cycles allowed for lock after pll_rst release (min 2).
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024: consecutive locked cycles required before core reset release (min 1).
REQ-004 SHALL have parameter MAX_RETRIES, default 3: PLL reset retries before fault (0..15).
REQ-005 SHALL have port refclk  input  1  sole clock; the 50 MHz PLL reference clock.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port pll_locked  input  1  PLL locked output, asynchronous to refclk.
REQ-008 SHALL have port retry_req  input  1  single-cycle pulse that restarts from FAULT.
REQ-009 SHALL have port pll_rst  output  1  drives the PLL rst input, active-high.
REQ-010 SHALL have port core_reset  output  1  active-high reset for downstream core logic.
REQ-011 SHALL have port ready  output  1  high only in RUN.
REQ-012 SHALL have port fault  output  1  high only in FAULT.
REQ-013 SHALL have port lol_count  output  8  loss-of-lock events seen in RUN, saturating at 255.

Function
REQ-014 SHALL pass pll_locked through a 2-flop synchronizer to locked_s (2-cycle latency); FSM uses only locked_s.
REQ-015 SHALL implement states PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT; all outputs registered.
REQ-016 PLL_RST: pll_rst=1 for exactly RST_CYCLES cycles, then WAIT_LOCK with cycle counter cleared.
REQ-017 WAIT_LOCK: pll_rst=0; locked_s=1 -> STABLE; else at counter==LOCK_TIMEOUT-1 -> PLL_RST with retries+1 if retries<MAX_RETRIES, otherwise FAULT.
REQ-018 Lock and timeout in the same cycle SHALL resolve as lock (-> STABLE, no retry).
REQ-019 STABLE: locked_s=0 -> WAIT_LOCK, counter cleared, retries unchanged; STABLE_CYCLES consecutive locked_s=1 -> RUN.
REQ-020 RUN: core_reset=0, ready=1; locked_s=0 -> PLL_RST, lol_count+1 (saturating), retries cleared.
REQ-021 core_reset SHALL be 1 in every state except RUN; it rises the cycle after locked_s is sampled low in RUN.
REQ-022 FAULT: pll_rst=1, core_reset=1, fault=1 held; retry_req -> PLL_RST with retries cleared; retry_req ignored in other states.
REQ-023 Counter width SHALL be clog2 of max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)+1; no wrap permitted.

Reset
REQ-024 rst=1 SHALL, on the next refclk edge, force PLL_RST with counter=0, retries=0, lol_count=0, synchronizer flops=0, pll_rst=1, core_reset=1, ready=0, fault=0, from any state including mid-count.
REQ-025 After rst deasserts, the PLL_RST pulse SHALL last the full RST_CYCLES.

Structure
REQ-026 Shared package pll_sup_pkg SHALL hold the state enum and the counter-width function.
REQ-027 Synchronizer SHALL be sub-module sync_2ff (1-bit, reset value 0); all else in one FSM module.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-028 Normal: release rst, raise pll_locked at cycle 6 -> pll_rst high cycles 1-4, ready=1 and core_reset=0 by cycle 17.
REQ-029 Timeout: pll_locked held 0 -> three PLL_RST pulses of 4 cycles, then fault=1, pll_rst=1; retry_req pulse -> new 4-cycle pulse, fault=0.
REQ-030 Glitch: pll_locked high 5 cycles, low 1, high -> returns to WAIT_LOCK, no retry; RUN reached 8+ cycles after the final rise.
REQ-031 Loss of lock in RUN: drop pll_locked -> core_reset=1 and ready=0 three cycles later, lol_count=1, pll_rst pulses 4 cycles.
REQ-032 Reset mid-STABLE: assert rst at stable count 5 -> next edge pll_rst=1, lol_count=0, core_reset=1; full sequence restarts.
